// File: rtl/gpu_pkg.sv
// Shared types and GPU register map for the APB command sequencer.
// The register addresses mirror the GPU's existing register definitions.
package gpu_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] data;
    } apb_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP
    } seq_state_t;

    localparam logic [APB_ADDR_W-1:0] GPU_REG_CTRL   = 32'h0000_0000;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_STATUS = 32'h0000_0004;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_BASE   = 32'h0000_0008;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_STRIDE = 32'h0000_000C;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_WIDTH  = 32'h0000_0010;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_HEIGHT = 32'h0000_0014;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_COLOR  = 32'h0000_0018;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_START  = 32'h0000_001C;

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: power-of-two ring buffer with registered count.
// A push into a full queue is accepted only when a pop frees a slot that cycle.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gpu_apb_sequencer.sv
// APB write master draining a command queue into the GPU register file,
// plus a pixel-stream monitor that reports pixel count and frame end.
module gpu_apb_sequencer
    import gpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int GAP    = 0,
    parameter int QUIET  = 16,
    parameter int CNT_W  = 20
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   cmd_push_i,
    input  logic [ADDR_W-1:0]      cmd_addr_i,
    input  logic [DATA_W-1:0]      cmd_data_i,
    output logic                   cmd_full_o,
    output logic [$clog2(DEPTH):0] cmd_count_o,
    output logic                   overflow_o,
    output logic [ADDR_W-1:0]      pAddr_o,
    output logic [DATA_W-1:0]      pDataWrite_o,
    output logic                   pSel_o,
    output logic                   pEnable_o,
    output logic                   pWrite_o,
    input  logic                   pReady_i,
    input  logic                   data_avail_i,
    output logic [CNT_W-1:0]       pixel_count_o,
    output logic                   frame_done_o,
    input  logic                   clear_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = $clog2(QUIET + 1);
    localparam int FW = ADDR_W + DATA_W;
    localparam logic [3:0] GAP_LAST = 4'(GAP > 0 ? GAP - 1 : 0);

    seq_state_t        state_q, state_d;
    logic [3:0]        gap_q, gap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  pix_q, pix_d;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic              seen_q, seen_d;
    logic              done_q, done_d;

    logic [FW-1:0]     head;
    logic              fifo_empty, pop, on_bus, more, active;

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (cmd_push_i),
        .wdata_i ({cmd_addr_i, cmd_data_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (cmd_full_o),
        .empty_o (fifo_empty),
        .count_o (cmd_count_o)
    );

    // Head entry stays in the queue until ACCESS completes, so it is stable
    // on the bus; the registers only hold the last value between transfers.
    assign on_bus       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign pAddr_o      = on_bus ? head[FW-1:DATA_W] : addr_q;
    assign pDataWrite_o = on_bus ? head[DATA_W-1:0] : data_q;
    assign addr_d       = pAddr_o;
    assign data_d       = pDataWrite_o;

    assign more   = (cmd_count_o > CW'(1)) || cmd_push_i;
    assign active = data_avail_i || cmd_push_i || (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        pSel_o    = 1'b0;
        pEnable_o = 1'b0;
        pWrite_o  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_SETUP;
            end
            S_SETUP: begin
                pSel_o   = 1'b1;
                pWrite_o = 1'b1;
                state_d  = S_ACCESS;
            end
            S_ACCESS: begin
                pSel_o    = 1'b1;
                pEnable_o = 1'b1;
                pWrite_o  = 1'b1;
                if (pReady_i) begin
                    pop = 1'b1;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = more ? S_SETUP : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = fifo_empty ? S_IDLE : S_SETUP;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q || (cmd_push_i && cmd_full_o && !pop);
        if (clear_i) ovf_d = 1'b0;

        pix_d = pix_q;
        if (clear_i) pix_d = '0;
        else if (data_avail_i && (pix_q != '1)) pix_d = pix_q + CNT_W'(1);

        quiet_d = quiet_q;
        if (active) quiet_d = '0;
        else if (quiet_q != QW'(QUIET)) quiet_d = quiet_q + QW'(1);

        // Fires on the edge the quiet count reaches QUIET; saturation stops repeats.
        done_d = !active && (quiet_q == QW'(QUIET - 1)) && seen_q;

        seen_d = seen_q;
        if (clear_i) seen_d = 1'b0;
        else if (data_avail_i) seen_d = 1'b1;
        else if (done_d) seen_d = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            pix_q   <= '0;
            quiet_q <= '0;
            seen_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            pix_q   <= pix_d;
            quiet_q <= quiet_d;
            seen_q  <= seen_d;
            done_q  <= done_d;
        end
    end

    assign overflow_o    = ovf_q;
    assign pixel_count_o = pix_q;
    assign frame_done_o  = done_q;

endmodule

// File: tb/tb_gpu_apb_sequencer.sv
// Directed bench for gpu_apb_sequencer: main instance at GAP=0,
// second instance at GAP=3 with a 4-bit pixel counter.
module tb_gpu_apb_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        push, ready, avail, clear;
    logic [31:0] caddr, cdata;
    logic        full, ovf, psel, pen, pwr, fdone;
    logic [3:0]  count;
    logic [31:0] paddr, pdata;
    logic [19:0] pix;

    logic        push_g, ready_g, avail_g, clear_g;
    logic [31:0] caddr_g, cdata_g;
    logic        full_g, ovf_g, psel_g, pen_g, pwr_g, fdone_g;
    logic [3:0]  count_g;
    logic [31:0] paddr_g, pdata_g;
    logic [3:0]  pix_g;

    int total = 0;
    int bad = 0;

    gpu_apb_sequencer dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_push_i(push), .cmd_addr_i(caddr), .cmd_data_i(cdata),
        .cmd_full_o(full), .cmd_count_o(count), .overflow_o(ovf),
        .pAddr_o(paddr), .pDataWrite_o(pdata),
        .pSel_o(psel), .pEnable_o(pen), .pWrite_o(pwr),
        .pReady_i(ready), .data_avail_i(avail),
        .pixel_count_o(pix), .frame_done_o(fdone), .clear_i(clear)
    );

    gpu_apb_sequencer #(.GAP(3), .CNT_W(4)) dut_g (
        .clk(clk), .n_rst(n_rst),
        .cmd_push_i(push_g), .cmd_addr_i(caddr_g), .cmd_data_i(cdata_g),
        .cmd_full_o(full_g), .cmd_count_o(count_g), .overflow_o(ovf_g),
        .pAddr_o(paddr_g), .pDataWrite_o(pdata_g),
        .pSel_o(psel_g), .pEnable_o(pen_g), .pWrite_o(pwr_g),
        .pReady_i(ready_g), .data_avail_i(avail_g),
        .pixel_count_o(pix_g), .frame_done_o(fdone_g), .clear_i(clear_g)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        push = 0; ready = 1; avail = 0; clear = 0; caddr = 0; cdata = 0;
        push_g = 0; ready_g = 1; avail_g = 0; clear_g = 0; caddr_g = 0; cdata_g = 0;
        #12;
        total++;
        if ({psel, pen, pwr, full, ovf, fdone} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=000000", {psel, pen, pwr, full, ovf, fdone});
        end
        total++;
        if ({paddr, pdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h exp=0", {paddr, pdata});
        end
        total++;
        if ({count, pix} !== 24'h0) begin
            bad++;
            $display("FAIL reset_counts got=%h exp=0", {count, pix});
        end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        ready = 1; caddr = 32'h4; cdata = 32'h00AB_CD01; push = 1;
        tick();
        push = 0;
        total++;
        if (count !== 4'd1 || psel !== 1'b0) begin
            bad++;
            $display("FAIL single_queued got=%0d/%b exp=1/0", count, psel);
        end
        tick();
        total++;
        if ({psel, pen, pwr} !== 3'b101 || paddr !== 32'h4 || pdata !== 32'h00AB_CD01) begin
            bad++;
            $display("FAIL single_setup got=%b %h %h exp=101 4 00abcd01", {psel, pen, pwr}, paddr, pdata);
        end
        tick();
        total++;
        if ({psel, pen, pwr} !== 3'b111 || paddr !== 32'h4 || count !== 4'd1) begin
            bad++;
            $display("FAIL single_access got=%b %h %0d exp=111 4 1", {psel, pen, pwr}, paddr, count);
        end
        tick();
        total++;
        if ({psel, pen, pwr} !== 3'b000 || count !== 4'd0 || paddr !== 32'h4) begin
            bad++;
            $display("FAIL single_done got=%b %0d %h exp=000 0 4", {psel, pen, pwr}, count, paddr);
        end
    endtask

    task automatic test_wait_states;
        ready = 0; caddr = 32'h8; cdata = 32'h2222_0008; push = 1;
        tick();
        push = 0;
        tick();
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) ready = 1;
            total++;
            if ({psel, pen} !== 2'b11 || paddr !== 32'h8 || pdata !== 32'h2222_0008 || count !== 4'd1) begin
                bad++;
                $display("FAIL wait_access%0d got=%b %h %h %0d exp=11 8 22220008 1", k, {psel, pen}, paddr, pdata, count);
            end
            tick();
        end
        total++;
        if (psel !== 1'b0 || count !== 4'd0) begin
            bad++;
            $display("FAIL wait_end got=%b %0d exp=0 0", psel, count);
        end
    endtask

    task automatic test_queue_full;
        int n;
        int last;
        ready = 0;
        for (int i = 0; i < 9; i++) begin
            push = 1; caddr = 32'h100 + 32'(4 * i); cdata = 32'hD000_0000 + 32'(i);
            tick();
            total++;
            if (count !== 4'((i < 8) ? i + 1 : 8) || full !== (i >= 7) || ovf !== (i == 8)) begin
                bad++;
                $display("FAIL full_push%0d got=%0d/%b/%b exp=%0d/%b/%b", i, count, full, ovf, (i < 8) ? i + 1 : 8, i >= 7, i == 8);
            end
        end
        push = 0;
        ready = 1;
        n = 0;
        last = -1;
        for (int c = 0; c < 40; c++) begin
            if (psel && pen && ready) begin
                total++;
                if (paddr !== 32'h100 + 32'(4 * n) || pdata !== 32'hD000_0000 + 32'(n)) begin
                    bad++;
                    $display("FAIL drain%0d got=%h %h exp=%h %h", n, paddr, pdata, 32'h100 + 32'(4 * n), 32'hD000_0000 + 32'(n));
                end
                if (last >= 0) begin
                    total++;
                    if (c - last != 2) begin
                        bad++;
                        $display("FAIL b2b_spacing%0d got=%0d exp=2", n, c - last);
                    end
                end
                last = c;
                n++;
            end
            tick();
        end
        total++;
        if (n != 8 || count !== 4'd0 || full !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL drain_total got=%0d %0d %b %b exp=8 0 0 1", n, count, full, ovf);
        end
        clear = 1;
        tick();
        clear = 0;
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b exp=0", ovf);
        end
    endtask

    task automatic test_gap;
        int idle;
        bit done1;
        bit got2;
        idle = 0; done1 = 0; got2 = 0;
        ready_g = 1;
        push_g = 1; caddr_g = 32'h10; cdata_g = 32'h1;
        tick();
        caddr_g = 32'h14; cdata_g = 32'h2;
        tick();
        push_g = 0;
        for (int c = 0; c < 20; c++) begin
            if (!got2) begin
                if (done1) begin
                    if (psel_g) begin
                        got2 = 1;
                        total++;
                        if (idle != 3 || paddr_g !== 32'h14 || pen_g !== 1'b0) begin
                            bad++;
                            $display("FAIL gap_idle got=%0d %h %b exp=3 14 0", idle, paddr_g, pen_g);
                        end
                    end else begin
                        idle++;
                    end
                end else if (psel_g && pen_g && ready_g) begin
                    done1 = 1;
                    total++;
                    if (paddr_g !== 32'h10) begin
                        bad++;
                        $display("FAIL gap_first got=%h exp=10", paddr_g);
                    end
                end
            end
            tick();
        end
        total++;
        if (!got2) begin
            bad++;
            $display("FAIL gap_timeout got=%b exp=1", got2);
        end
    endtask

    task automatic test_pixel_saturate;
        avail_g = 1;
        repeat (20) tick();
        avail_g = 0;
        total++;
        if (pix_g !== 4'hF) begin
            bad++;
            $display("FAIL pix_sat got=%0d exp=15", pix_g);
        end
        avail_g = 1; clear_g = 1;
        tick();
        clear_g = 0;
        total++;
        if (pix_g !== 4'h0) begin
            bad++;
            $display("FAIL clear_prio got=%0d exp=0", pix_g);
        end
        tick();
        avail_g = 0;
        total++;
        if (pix_g !== 4'h1) begin
            bad++;
            $display("FAIL pix_after_clear got=%0d exp=1", pix_g);
        end
    endtask

    task automatic test_frame_done;
        int pulses;
        int first_k;
        pulses = 0; first_k = -1;
        avail = 1;
        repeat (100) tick();
        avail = 0;
        total++;
        if (pix !== 20'd100 || fdone !== 1'b0) begin
            bad++;
            $display("FAIL pix_100 got=%0d %b exp=100 0", pix, fdone);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (fdone) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        total++;
        if (pulses != 1 || first_k != 16) begin
            bad++;
            $display("FAIL frame_pulse got=%0d@%0d exp=1@16", pulses, first_k);
        end
        clear = 1;
        tick();
        clear = 0;
        total++;
        if (pix !== 20'd0) begin
            bad++;
            $display("FAIL pix_clear got=%0d exp=0", pix);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 0;
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            push = 1; caddr = 32'h200 + 32'(4 * i); cdata = 32'hE0 + 32'(i);
            tick();
        end
        push = 0;
        total++;
        if (pen !== 1'b1 || count !== 4'd3) begin
            bad++;
            $display("FAIL mid_pre got=%b %0d exp=1 3", pen, count);
        end
        n_rst = 1'b0;
        #1;
        total++;
        if ({psel, pen, pwr} !== 3'b000 || paddr !== 32'h0 || pdata !== 32'h0 || count !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b %h %h %0d exp=000 0 0 0", {psel, pen, pwr}, paddr, pdata, count);
        end
        #2;
        n_rst = 1'b1;
        ready = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (psel) seen = 1;
        end
        total++;
        if (seen || count !== 4'd0) begin
            bad++;
            $display("FAIL mid_after got=%b %0d exp=0 0", seen, count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_wait_states();
        test_queue_full();
        test_gap();
        test_pixel_saturate();
        test_frame_done();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_apb_sequencer.md
# gpu_apb_sequencer

Synthesizable APB write-master that replaces hand-sequenced register writes into `gpu`. Host logic pushes (address, data) command pairs into an internal queue. The block issues them as APB write transfers with `pReady` wait-state support and a programmable inter-transfer gap. It also monitors the GPU pixel stream (`data_avail`) and reports pixel count and frame completion.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB write-data width
- DEPTH, 8, command queue entries (power of two, ≥2)
- GAP, 0, idle cycles forced between consecutive transfers (0..15)
- QUIET, 16, cycles of `data_avail` low, with the queue empty, needed to declare a frame done
- CNT_W, 20, pixel counter width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- n_rst  in  1  asynchronous, active-low reset
- cmd_push_i  in  1  enqueue request
- cmd_addr_i  in  ADDR_W  command address
- cmd_data_i  in  DATA_W  command data
- cmd_full_o  out  1  queue full
- cmd_count_o  out  $clog2(DEPTH)+1  entries queued, including any entry in flight
- overflow_o  out  1  sticky; set by a push while full
- pAddr_o  out  ADDR_W  APB address
- pDataWrite_o  out  DATA_W  APB write data
- pSel_o, pEnable_o, pWrite_o  out  1 each  APB controls
- pReady_i  in  1  APB slave ready; tie high for a slave with no wait states
- data_avail_i  in  1  GPU pixel-valid strobe
- pixel_count_o  out  CNT_W  pixels seen since the last clear
- frame_done_o  out  1  one-cycle pulse at frame end
- clear_i  in  1  synchronous clear of pixel_count_o and overflow_o

## Operation
- FSM states: IDLE, SETUP, ACCESS, GAP.
- IDLE: moves to SETUP when the queue is non-empty.
- SETUP: drives `pSel=1`, `pEnable=0`, `pWrite=1`, with the head entry on `pAddr_o`/`pDataWrite_o`. Always lasts exactly 1 cycle, then moves to ACCESS.
- ACCESS: drives `pSel=1`, `pEnable=1`. Stays while `pReady_i=0`.
  - When `pReady_i=1`: the head entry is popped.
  - Next state is GAP if GAP>0.
  - Otherwise, SETUP if the queue is still non-empty, else IDLE.
- GAP: all APB controls are 0. Counts GAP cycles, then moves to SETUP or IDLE.
- Address and data stay stable from SETUP through the end of ACCESS.
- Outside SETUP/ACCESS: `pAddr_o`/`pDataWrite_o` hold their last value and `pWrite_o=0`.
- Queue:
  - A push is accepted when not full.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - A push while full (and no pop that cycle) is dropped and sets `overflow_o`.
  - Pointers wrap modulo DEPTH.
- Pixel monitor:
  - `pixel_count_o` increments on every cycle with `data_avail_i=1`.
  - Saturates at all-ones; it does not wrap.
- Frame completion:
  - A quiet counter resets on any `data_avail_i`, queue push, or non-IDLE state.
  - When the count reaches QUIET, `frame_done_o` pulses once, but only if at least one pixel was seen since the last pulse or clear.
- `clear_i` has priority over a simultaneous increment; the counter becomes 0 that cycle.

## Timing
- Reset values: all outputs 0. FSM goes to IDLE, queue empty, all counters 0. Reset mid-transfer aborts the transfer immediately and discards all queued commands.
- Push to bus: a push accepted at edge N with the queue empty and FSM in IDLE puts SETUP on the bus in cycle N+1.
- Zero-wait transfer: 2 cycles. Back-to-back throughput at GAP=0 is one command per 2 cycles.
- `cmd_full_o` and `cmd_count_o` are registered and reflect the state after the edge.
- `frame_done_o`: high for exactly one cycle, QUIET cycles after the last qualifying activity.

## Structure
- Shared package `gpu_pkg`:
  - `apb_cmd_t` struct {addr, data}
  - FSM state enum `seq_state_t`
  - APB address constants for GPU registers, taken from the existing `gpu_definitions.vh` values
- Sub-module `cmd_fifo` (parametrised DEPTH and width; push, pop, full, empty, count). The sequencer FSM and pixel monitor live in the top module.

## Test plan
- Single command: push {0x4, 0x00AB_CD01}, `pReady` tied high → SETUP in cycle 1, ACCESS in cycle 2, `pAddr=0x4`, `pDataWrite=0x00ABCD01`, `cmd_count` returns 1→0.
- Wait states: hold `pReady_i=0` for 3 cycles → ACCESS lasts 4 cycles; addr/data stable throughout; exactly one pop.
- Queue full: DEPTH=8; push 9 commands in consecutive cycles while `pReady_i=0` → `cmd_full_o=1` after the 8th push, `overflow_o=1`, 9th command never appears on the bus; release `pReady_i` → 8 transfers in push order.
- Gap: GAP=3 with 2 queued commands → exactly 3 idle cycles between the first ACCESS completing and the second SETUP.
- Frame done: 100 cycles of `data_avail_i=1`, then low → `pixel_count_o=100`; `frame_done_o` pulses once, 16 cycles after the last pixel; no second pulse.
- Reset mid-ACCESS with 3 entries queued → all APB outputs 0 immediately; `cmd_count_o=0`; no transfer after reset release.
